// File: rtl/l2_req_scheduler.sv
// L2 request scheduler: arbitrates icache, dcache and prefetcher line requests
// onto a single L2 port, one transaction at a time. Dcache normally wins, but
// a bounded run of dcache grants while icache waits forces an icache grant.
module l2_req_scheduler #(
    parameter int unsigned MAX_D_BURST = 3
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    input  logic         p_read,
    input  logic [31:0]  p_address,
    output logic [255:0] p_rdata,
    output logic         p_resp,

    output logic         l2_read,
    output logic         l2_write,
    output logic [31:0]  l2_address,
    output logic [255:0] l2_wdata,
    input  logic [255:0] l2_rdata,
    input  logic         l2_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SERV_D = 2'd1;
    localparam logic [1:0] SERV_I = 2'd2;
    localparam logic [1:0] SERV_P = 2'd3;

    // Streak counter is 4 bits, enough for the legal burst range 1..15.
    localparam logic [3:0] D_BURST    = 4'(MAX_D_BURST);
    localparam logic [3:0] STREAK_SAT = 4'hF;

    logic [1:0]   state_q, state_d;
    logic [3:0]   d_streak_q, d_streak_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wdata_q, wdata_d;
    logic         write_q, write_d;

    logic         d_req;
    logic         i_force;
    logic         grant_d;
    logic         grant_i;
    logic         grant_p;
    logic [3:0]   streak_inc;

    // Arbitration among requests sampled in the current cycle.
    always_comb begin
        d_req   = d_read | d_write;
        // Icache overrides dcache only once the dcache run has hit the limit.
        i_force = i_read && (d_streak_q == D_BURST);
        grant_d = d_req && !i_force;
        grant_i = i_read && !grant_d;
        // Prefetch only gets the port when nobody else is asking.
        grant_p = p_read && !d_req && !i_read;
        streak_inc = (d_streak_q == STREAK_SAT) ? STREAK_SAT : d_streak_q + 4'd1;
    end

    // Next-state: grant in IDLE, hold in SERV_x until l2_resp, then back to IDLE.
    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERV_D;
                    addr_d  = d_address;
                    // A simultaneous read+write is served as a writeback.
                    write_d = d_write;
                    wdata_d = d_write ? d_wdata : '0;
                    // Only count dcache grants that actually made icache wait.
                    d_streak_d = i_read ? streak_inc : 4'd0;
                end else if (grant_i) begin
                    state_d    = SERV_I;
                    addr_d     = i_address;
                    write_d    = 1'b0;
                    wdata_d    = '0;
                    d_streak_d = 4'd0;
                end else if (grant_p) begin
                    state_d = SERV_P;
                    addr_d  = p_address;
                    write_d = 1'b0;
                    wdata_d = '0;
                end
            end
            SERV_D, SERV_I, SERV_P: begin
                // Requester drops are ignored; the transaction always completes.
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction registers, async cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            d_streak_q <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
        end
    end

    // L2 command and requester completions, driven only from state and latches.
    always_comb begin
        l2_read    = (state_q != IDLE) && !write_q;
        l2_write   = (state_q == SERV_D) && write_q;
        l2_address = addr_q;
        l2_wdata   = wdata_q;

        // l2_resp in IDLE matches no SERV state and so produces no completion.
        d_resp = (state_q == SERV_D) && l2_resp;
        i_resp = (state_q == SERV_I) && l2_resp;
        p_resp = (state_q == SERV_P) && l2_resp;

        // Read data is broadcast; each *_resp alone qualifies it.
        i_rdata = l2_rdata;
        d_rdata = l2_rdata;
        p_rdata = l2_rdata;
    end

endmodule

// File: tb/tb_l2_req_scheduler.sv
// Bench for l2_req_scheduler: directed scenarios plus a randomized run checked
// against a transaction-level arbitration model.
module tb_l2_req_scheduler;

    localparam int MAXB = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_read, d_read, d_write, p_read;
    logic [31:0]  i_address, d_address, p_address;
    logic [255:0] d_wdata;
    logic [255:0] i_rdata, d_rdata, p_rdata;
    logic         i_resp, d_resp, p_resp;
    logic         l2_read, l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit           ok;
        logic [31:0]  addr;
        logic         wr;
        logic         rd;
        logic [255:0] wdata;
        int           cmd_cycles;
        int           pulses;
        int           who;
        logic [255:0] rdata;
        int           gap;
        bit           stable;
        bit           fanout_ok;
    } txn_t;

    always #5 clk = ~clk;

    l2_req_scheduler #(.MAX_D_BURST(MAXB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .p_read     (p_read),
        .p_address  (p_address),
        .p_rdata    (p_rdata),
        .p_resp     (p_resp),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp)
    );

    function automatic logic [31:0] rand_addr();
        return $urandom() & 32'hFFFF_FFE0;
    endfunction

    task automatic clear_reqs();
        i_read = 0; d_read = 0; d_write = 0; p_read = 0;
    endtask

    // Leaves the bench at posedge+1 of an IDLE cycle with no requests.
    task automatic do_reset();
        clear_reqs();
        l2_resp = 0;
        reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Acts as the L2 memory for one transaction; responds on the lat-th command cycle.
    task automatic serve(input int lat, input logic [255:0] rd, input bit drop_i,
                         output txn_t t);
        int m;
        int waited;
        t.ok = 0; t.addr = 0; t.wr = 0; t.rd = 0; t.wdata = 0; t.cmd_cycles = 0;
        t.pulses = 0; t.who = 0; t.rdata = 0; t.gap = 0; t.stable = 1; t.fanout_ok = 1;
        waited = 0;
        while (waited < 20) begin
            @(negedge clk);
            t.pulses += int'(i_resp) + int'(d_resp) + int'(p_resp);
            if (l2_read || l2_write) break;
            waited++;
        end
        t.gap = waited;
        if (!(l2_read || l2_write)) return;
        t.ok = 1;
        t.addr = l2_address;
        t.wr = l2_write;
        t.rd = l2_read;
        t.wdata = l2_wdata;
        t.cmd_cycles = 1;
        m = 1;
        while (m < lat) begin
            @(posedge clk);
            #1;
            m++;
            if (m == 2 && drop_i) i_read = 0;
            l2_rdata = (m == lat) ? rd : {8{$urandom()}};
            l2_resp = (m == lat);
            @(negedge clk);
            if (l2_read || l2_write) t.cmd_cycles++;
            if (l2_address !== t.addr || l2_write !== t.wr) t.stable = 0;
            if (i_rdata !== l2_rdata || d_rdata !== l2_rdata || p_rdata !== l2_rdata)
                t.fanout_ok = 0;
            t.pulses += int'(i_resp) + int'(d_resp) + int'(p_resp);
            if (d_resp) begin t.who = 1; t.rdata = d_rdata; end
            if (i_resp) begin t.who = 2; t.rdata = i_rdata; end
            if (p_resp) begin t.who = 3; t.rdata = p_rdata; end
        end
        @(posedge clk);
        #1;
        l2_resp = 0;
    endtask

    task automatic test_reset();
        clear_reqs();
        l2_resp = 0; l2_rdata = 0; d_wdata = 0;
        i_address = 0; d_address = 0; p_address = 0;
        reset_n = 1;
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (l2_read !== 1'b0) begin errors++;
            $display("FAIL reset_l2_read: got %b want 0", l2_read); end
        checks++;
        if (l2_write !== 1'b0) begin errors++;
            $display("FAIL reset_l2_write: got %b want 0", l2_write); end
        checks++;
        if ({i_resp, d_resp, p_resp} !== 3'b000) begin errors++;
            $display("FAIL reset_resp: got %b want 000", {i_resp, d_resp, p_resp}); end
        checks++;
        if (l2_address !== 32'd0) begin errors++;
            $display("FAIL reset_addr: got %h want 0", l2_address); end
        checks++;
        if (l2_wdata !== 256'd0) begin errors++;
            $display("FAIL reset_wdata: got %h want 0", l2_wdata); end
        do_reset();
    endtask

    task automatic test_single_icache();
        txn_t t;
        logic [255:0] pat;
        pat = {32{8'hA5}};
        i_read = 1; i_address = 32'h0000_1040;
        serve(4, pat, 0, t);
        i_read = 0;
        checks++;
        if (!t.ok || t.who != 2) begin errors++;
            $display("FAIL icache_grant: ok=%0d who=%0d want who=2", t.ok, t.who); end
        checks++;
        if (t.addr !== 32'h0000_1040 || t.rd !== 1'b1 || t.wr !== 1'b0) begin errors++;
            $display("FAIL icache_cmd: addr=%h rd=%b wr=%b want 00001040 1 0",
                     t.addr, t.rd, t.wr); end
        checks++;
        if (t.cmd_cycles != 4) begin errors++;
            $display("FAIL icache_cmd_len: got %0d want 4", t.cmd_cycles); end
        checks++;
        if (t.pulses != 1 || t.rdata !== pat) begin errors++;
            $display("FAIL icache_resp: pulses=%0d rdata=%h want 1 pulse of A5..", t.pulses,
                     t.rdata); end
        @(negedge clk);
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || i_resp !== 1'b0) begin errors++;
            $display("FAIL icache_idle_after: rd=%b wr=%b resp=%b want 0 0 0",
                     l2_read, l2_write, i_resp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_priority();
        txn_t t;
        do_reset();
        d_write = 1; d_address = 32'h0000_2000; d_wdata = {32{8'h11}};
        i_read = 1; i_address = 32'h0000_1000;
        serve(3, 256'd0, 0, t);
        d_write = 0;
        checks++;
        if (!t.ok || t.who != 1 || t.wr !== 1'b1 || t.rd !== 1'b0) begin errors++;
            $display("FAIL wprio_first: ok=%0d who=%0d wr=%b rd=%b want who=1 wr=1 rd=0",
                     t.ok, t.who, t.wr, t.rd); end
        checks++;
        if (t.addr !== 32'h0000_2000 || t.wdata !== {32{8'h11}}) begin errors++;
            $display("FAIL wprio_payload: addr=%h wdata=%h want 2000 11..", t.addr, t.wdata); end
        serve(2, {8{32'hCAFE_0001}}, 0, t);
        i_read = 0;
        checks++;
        if (!t.ok || t.who != 2 || t.addr !== 32'h0000_1000 || t.rd !== 1'b1) begin errors++;
            $display("FAIL wprio_second: ok=%0d who=%0d addr=%h want who=2 addr=1000",
                     t.ok, t.who, t.addr); end
        checks++;
        if (t.gap != 1) begin errors++;
            $display("FAIL wprio_idle_gap: got %0d idle cycles want 1", t.gap); end
    endtask

    task automatic test_starvation();
        txn_t t;
        int exp_order[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
        do_reset();
        i_read = 1; i_address = 32'h0000_3000;
        d_read = 1; d_address = 32'h0000_8000;
        for (int k = 0; k < 8; k++) begin
            serve(2, {8{$urandom()}}, 0, t);
            d_address = d_address + 32'h20;
            checks++;
            if (!t.ok || t.who != exp_order[k]) begin errors++;
                $display("FAIL starve_order[%0d]: ok=%0d who=%0d want %0d", k, t.ok, t.who,
                         exp_order[k]); end
        end
        clear_reqs();
    endtask

    task automatic test_prefetch();
        txn_t t;
        i_read = 1; i_address = 32'h0000_4400;
        p_read = 1; p_address = 32'h0000_9900;
        serve(2, {8{32'h1234_5678}}, 0, t);
        i_read = 0;
        checks++;
        if (!t.ok || t.who != 2) begin errors++;
            $display("FAIL pf_i_first: ok=%0d who=%0d want 2", t.ok, t.who); end
        serve(3, {8{32'h8765_4321}}, 0, t);
        checks++;
        if (!t.ok || t.who != 3 || t.addr !== 32'h0000_9900) begin errors++;
            $display("FAIL pf_granted: ok=%0d who=%0d addr=%h want 3 9900", t.ok, t.who,
                     t.addr); end
        d_read = 1; d_address = 32'h0000_7700;
        serve(2, {8{32'h0BAD_F00D}}, 0, t);
        d_read = 0;
        checks++;
        if (!t.ok || t.who != 1) begin errors++;
            $display("FAIL pf_d_first: ok=%0d who=%0d want 1", t.ok, t.who); end
        serve(2, {8{32'h0000_0042}}, 0, t);
        p_read = 0;
        checks++;
        if (!t.ok || t.who != 3) begin errors++;
            $display("FAIL pf_after_d: ok=%0d who=%0d want 3", t.ok, t.who); end
    endtask

    task automatic test_protocol_edges();
        txn_t t;
        // Stray l2_resp while idle.
        l2_rdata = {8{32'hDEAD_BEEF}};
        l2_resp = 1;
        @(negedge clk);
        checks++;
        if ({i_resp, d_resp, p_resp} !== 3'b000) begin errors++;
            $display("FAIL idle_resp: got %b want 000", {i_resp, d_resp, p_resp}); end
        @(posedge clk);
        #1;
        l2_resp = 0;
        @(negedge clk);
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0) begin errors++;
            $display("FAIL idle_resp_state: rd=%b wr=%b want 0 0", l2_read, l2_write); end
        @(posedge clk);
        #1;
        // Read and write together is a write.
        d_read = 1; d_write = 1; d_address = 32'h0000_6000; d_wdata = {8{32'h5555_AAAA}};
        serve(2, 256'd0, 0, t);
        d_read = 0; d_write = 0;
        checks++;
        if (!t.ok || t.who != 1 || t.wr !== 1'b1 || t.rd !== 1'b0) begin errors++;
            $display("FAIL rw_both: ok=%0d who=%0d wr=%b rd=%b want 1 1 0",
                     t.ok, t.who, t.wr, t.rd); end
        // Icache drops its request mid-service.
        i_read = 1; i_address = 32'h0000_0A00;
        serve(4, {8{32'h7777_0000}}, 1, t);
        i_read = 0;
        checks++;
        if (!t.ok || t.who != 2 || t.pulses != 1 || t.cmd_cycles != 4) begin errors++;
            $display("FAIL drop_mid: ok=%0d who=%0d pulses=%0d len=%0d want 2 1 4",
                     t.ok, t.who, t.pulses, t.cmd_cycles); end
        @(negedge clk);
        checks++;
        if (l2_read !== 1'b0 || i_resp !== 1'b0) begin errors++;
            $display("FAIL drop_mid_idle: rd=%b resp=%b want 0 0", l2_read, i_resp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        txn_t t;
        int waited;
        do_reset();
        // Build the dcache streak to the limit, then reset during the third grant.
        i_read = 1; i_address = 32'h0000_0100;
        d_read = 1; d_address = 32'h0000_0200;
        serve(2, 256'd0, 0, t);
        serve(2, 256'd0, 0, t);
        d_read = 0; d_write = 1; d_address = 32'h0000_4000; d_wdata = {8{$urandom()}};
        waited = 0;
        while (waited < 20) begin
            @(negedge clk);
            if (l2_write) break;
            waited++;
        end
        checks++;
        if (l2_write !== 1'b1) begin errors++;
            $display("FAIL rst_mid_cmd: l2_write=%b want 1", l2_write); end
        #1;
        l2_resp = 1;
        reset_n = 0;
        #1;
        checks++;
        if (l2_write !== 1'b0 || l2_read !== 1'b0) begin errors++;
            $display("FAIL rst_mid_cmd_clear: wr=%b rd=%b want 0 0", l2_write, l2_read); end
        checks++;
        if ({i_resp, d_resp, p_resp} !== 3'b000) begin errors++;
            $display("FAIL rst_mid_resp: got %b want 000", {i_resp, d_resp, p_resp}); end
        checks++;
        if (l2_address !== 32'd0 || l2_wdata !== 256'd0) begin errors++;
            $display("FAIL rst_mid_latch: addr=%h wdata=%h want 0 0", l2_address, l2_wdata); end
        @(posedge clk);
        #1;
        l2_resp = 0;
        d_write = 0; d_read = 1; d_address = 32'h0000_5000;
        @(negedge clk);
        reset_n = 1;
        // With a cleared streak dcache must win again despite icache waiting.
        serve(2, 256'd0, 0, t);
        clear_reqs();
        checks++;
        if (!t.ok || t.who != 1 || t.addr !== 32'h0000_5000) begin errors++;
            $display("FAIL rst_mid_streak: ok=%0d who=%0d addr=%h want 1 5000", t.ok, t.who,
                     t.addr); end
    endtask

    task automatic test_random();
        txn_t t;
        bit dp, ip, pp;
        int dkind, streak, expw, lat;
        logic [31:0] da, ia, pa, ea;
        logic [255:0] dwd, rd;
        logic ew;
        do_reset();
        dp = 0; ip = 0; pp = 0; dkind = 0; streak = 0;
        da = 0; ia = 0; pa = 0; dwd = 0;
        for (int n = 0; n < 80; n++) begin
            if (!dp && $urandom_range(0, 99) < 60) begin
                dp = 1; dkind = $urandom_range(0, 2); da = rand_addr(); dwd = {8{$urandom()}};
            end
            if (!ip && $urandom_range(0, 99) < 50) begin ip = 1; ia = rand_addr(); end
            if (!pp && $urandom_range(0, 99) < 40) begin pp = 1; pa = rand_addr(); end
            if (!dp && !ip && !pp) begin pp = 1; pa = rand_addr(); end
            d_read = dp && dkind != 1;
            d_write = dp && dkind != 0;
            d_address = da; d_wdata = dwd;
            i_read = ip; i_address = ia;
            p_read = pp; p_address = pa;
            // Reference arbitration from the priority and fairness rules.
            if (dp && !(ip && streak == MAXB)) begin
                expw = 1; ea = da; ew = (dkind != 0);
                streak = ip ? ((streak < 15) ? streak + 1 : 15) : 0;
                dp = 0;
            end else if (ip) begin
                expw = 2; ea = ia; ew = 0; streak = 0; ip = 0;
            end else begin
                expw = 3; ea = pa; ew = 0; pp = 0;
            end
            lat = $urandom_range(2, 5);
            rd = {8{$urandom()}};
            serve(lat, rd, 0, t);
            checks++;
            if (!t.ok || t.who != expw) begin errors++;
                $display("FAIL rnd[%0d]_grant: ok=%0d who=%0d want %0d", n, t.ok, t.who, expw); end
            checks++;
            if (t.addr !== ea || t.wr !== ew || t.rd !== !ew) begin errors++;
                $display("FAIL rnd[%0d]_cmd: addr=%h wr=%b rd=%b want %h %b %b", n, t.addr,
                         t.wr, t.rd, ea, ew, !ew); end
            if (ew) begin
                checks++;
                if (t.wdata !== dwd) begin errors++;
                    $display("FAIL rnd[%0d]_wdata: got %h want %h", n, t.wdata, dwd); end
            end
            checks++;
            if (t.cmd_cycles != lat || !t.stable) begin errors++;
                $display("FAIL rnd[%0d]_hold: len=%0d stable=%0d want %0d 1", n, t.cmd_cycles,
                         t.stable, lat); end
            checks++;
            if (t.pulses != 1 || t.rdata !== rd || !t.fanout_ok) begin errors++;
                $display("FAIL rnd[%0d]_resp: pulses=%0d rdata=%h fanout=%0d want 1 %h 1", n,
                         t.pulses, t.rdata, t.fanout_ok, rd); end
            checks++;
            if (t.gap != 1) begin errors++;
                $display("FAIL rnd[%0d]_gap: got %0d want 1", n, t.gap); end
        end
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_single_icache();
        test_write_priority();
        test_starvation();
        test_prefetch();
        test_protocol_edges();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
